display_mux: RTL

DISPLAY_MUX -- requirements
Module: display_mux

---
 rtl/display_mux.sv | 117 +++++++++++
 1 files changed

// File: rtl/display_mux.sv
// Multiplexed seven-segment driver: scans DIGITS hex digits, one slot per PRESCALE cycles.
// Define DISPLAY_MUX_LZB_EN to blank leading zeros on every digit except digit 0.
module display_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   valor_i,
  input  logic                  load_i,
  input  logic                  enable_i,
  output logic [0:6]            display_o,
  output logic [DIGITS-1:0]     anodo_o,
  output logic [2:0]            digito_o
);

  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [2:0]      IDX_MAX   = 3'(DIGITS - 1);

  logic [PW-1:0]         presc_q,   presc_d;
  logic [2:0]            index_q,   index_d;
  logic [4*DIGITS-1:0]   value_q,   value_d;
  logic [0:6]            display_q, display_d;
  logic [DIGITS-1:0]     anodo_q,   anodo_d;
  logic [2:0]            digito_q,  digito_d;

  logic       tick;
  logic [3:0] nibble;
  logic       blank;
  logic [0:6] pattern;
`ifdef DISPLAY_MUX_LZB_EN
  logic       upper_zero;
`endif

  // Scan timing and value capture; a load never disturbs the prescaler or index.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    index_d = index_q;
    if (tick) begin
      index_d = (index_q == IDX_MAX) ? 3'd0 : index_q + 3'd1;
    end
    value_d = load_i ? valor_i : value_q;
  end

  // Digit data for the current index, decoded from the registered value.
  always_comb begin
    nibble = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (index_q == 3'(k)) nibble = value_q[4*k +: 4];
    end

`ifdef DISPLAY_MUX_LZB_EN
    blank      = 1'b0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (value_q[4*k +: 4] == 4'h0);
      if ((index_q == 3'(k)) && upper_zero) blank = 1'b1;
    end
`else
    blank = 1'b0;
`endif

    // Literals read left to right as display_o[0:6] = g,f,e,d,c,b,a.
    case (nibble)
      4'h0:    pattern = 7'b0111111;
      4'h1:    pattern = 7'b0000110;
      4'h2:    pattern = 7'b1011011;
      4'h3:    pattern = 7'b1001111;
      4'h4:    pattern = 7'b1100110;
      4'h5:    pattern = 7'b1101101;
      4'h6:    pattern = 7'b1111101;
      4'h7:    pattern = 7'b0000111;
      4'h8:    pattern = 7'b1111111;
      4'h9:    pattern = 7'b1101111;
      4'hA:    pattern = 7'b1110111;
      4'hB:    pattern = 7'b1111100;
      4'hC:    pattern = 7'b0111001;
      4'hD:    pattern = 7'b1011110;
      4'hE:    pattern = 7'b1111001;
      default: pattern = 7'b1110001;
    endcase
    if (blank) pattern = 7'b0000000;

    display_d = enable_i ? pattern : ~pattern;
    for (int k = 0; k < DIGITS; k++) begin
      anodo_d[k] = (index_q != 3'(k));
    end
    digito_d = index_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      index_q   <= 3'd0;
      value_q   <= '0;
      display_q <= 7'b0000000;
      anodo_q   <= '1;
      digito_q  <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      presc_q   <= presc_d;
      index_q   <= index_d;
      value_q   <= value_d;
      display_q <= display_d;
      anodo_q   <= anodo_d;
      digito_q  <= digito_d;
    end
  end

  assign display_o = display_q;
  assign anodo_o   = anodo_q;
  assign digito_o  = digito_q;

endmodule
